pupil_scan_scheduler: RTL and testbench
=======================================

PUPIL_SCAN_SCHEDULER -- requirements
Module: pupil_scan_scheduler

Interface
REQ-001 Parameter IMG_W, default 512, SHALL set the image width in pixels; X coordinates are 0..IMG_W-1.
REQ-002 Parameter IMG_H, default 384, SHALL set the image height in pixels; Y coordinates are 0..IMG_H-1.
REQ-003 Parameter CORR_W, default 16, SHALL set the correlation score width in bits; scores are unsigned.
REQ-004 Parameter STEP, default 1, SHALL set the scan stride in pixels for both X and Y (range 1..15).
REQ-005 Parameter TIMEOUT, default 1023, SHALL set the correlator response watchdog limit in cycles (SCAN_TIMEOUT_EN only).
REQ-006 iCLK  in  1  SHALL be the single clock; all flops update on its rising edge.
REQ-007 iRST_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-008 iFrameDone  in  1  SHALL be a single-cycle pulse that starts a scan.
REQ-009 iXmin/iXmax  in  10 each  SHALL give the ROI X bounds (inclusive), latched on an accepted iFrameDone.
REQ-010 iYmin/iYmax  in  9 each  SHALL give the ROI Y bounds (inclusive), latched on an accepted iFrameDone.
REQ-011 oCorrStart  out  1  SHALL be a one-cycle pulse requesting one correlation at (oX,oY).
REQ-012 oX/oY  out  10/9  SHALL be the candidate position, stable from oCorrStart until the matching iCorrDone.
REQ-013 iCorrDone  in  1  SHALL be the correlator completion pulse; iCorrValue  in  CORR_W  SHALL be valid with it.
REQ-014 oXresult/oYresult/oBestCorr  out  10/9/CORR_W  SHALL be the argmax position and score of the last completed scan.
REQ-015 oResultValid  out  1  SHALL pulse for one cycle when those results update; oBusy  out  1  SHALL be high in any state except IDLE.
REQ-016 oDropCnt  out  8  SHALL count iFrameDone pulses ignored while busy.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, UPDATE, DONE.
REQ-018 In IDLE, iFrameDone SHALL latch the ROI, set (oX,oY)=(Xmin,Ymin), and go to ISSUE; oCorrStart asserts on the next cycle.
REQ-019 ISSUE SHALL last one cycle with oCorrStart=1, then go to WAIT.
REQ-020 WAIT SHALL hold until iCorrDone=1, then go to UPDATE; iCorrDone outside WAIT SHALL be ignored.
REQ-021 UPDATE (1 cycle): for the first position of a scan, the best score and position SHALL be loaded unconditionally; otherwise they SHALL be replaced only if iCorrValue is strictly greater (ties keep the earlier raster position).
REQ-022 Advance: if oX+STEP<=Xmax then oX+=STEP; else oX=Xmin and, if oY+STEP<=Ymax, oY+=STEP, else go to DONE; otherwise go to ISSUE.
REQ-023 Advance arithmetic SHALL use 11/10-bit sums so no wrap-around occurs at IMG_W-1/IMG_H-1.
REQ-024 Bounds SHALL be clamped at latch time to IMG_W-1/IMG_H-1; if Xmin>Xmax or Ymin>Ymax, the FSM SHALL go directly to DONE with result (Xmin,Ymin), score 0, and no oCorrStart.
REQ-025 DONE (1 cycle) SHALL copy the best values to the outputs, pulse oResultValid, and go to IDLE; the results SHALL hold until the next DONE.
REQ-026 iFrameDone in any state other than IDLE SHALL be ignored and SHALL increment oDropCnt, which saturates at 255.

Reset
REQ-027 Asserting iRST_N low SHALL immediately force IDLE and zero every output and internal register, including during a scan in progress; no oResultValid SHALL be produced for an aborted scan.

Configuration
REQ-028 With SCAN_TIMEOUT_EN defined, a WAIT lasting TIMEOUT cycles SHALL be treated as iCorrValue=0, proceed to UPDATE, and set sticky output oTimeout (cleared on the next accepted iFrameDone).
REQ-029 Without SCAN_TIMEOUT_EN, WAIT SHALL wait indefinitely and the oTimeout port SHALL NOT exist.

Structure
REQ-030 A shared package pupil_pkg SHALL hold the state enum, the coordinate widths (10/9) and the IMG_W/IMG_H defaults.
REQ-031 The raster stepping SHALL be a sub-module roi_raster_counter (load, step, last flag); compare and FSM logic SHALL remain in the top module.

Verification
REQ-032 ROI (0..2,0..1), STEP=1, scores 5,9,3,9,1,2 -> 6 oCorrStart pulses; result (1,0), score 9; one oResultValid.
REQ-033 ROI (509..511,382..383), STEP=2 -> positions (509,382),(511,382) only; no coordinate overflow.
REQ-034 Xmin=10, Xmax=5 -> oResultValid 2 cycles after iFrameDone with result (10,Ymin), score 0, zero oCorrStart pulses.
REQ-035 Three iFrameDone pulses mid-scan -> oDropCnt=3 and the scan completes unaffected; 300 pulses -> oDropCnt=255.
REQ-036 iRST_N low during WAIT -> all outputs 0 and oBusy=0 in the same cycle; a later iCorrDone is ignored.
REQ-037 SCAN_TIMEOUT_EN, TIMEOUT=8, correlator silent -> UPDATE after 8 WAIT cycles; oTimeout=1; scan continues.

Source files
------------

// File: rtl/pupil_pkg.sv
// Shared types for the pupil scan scheduler: FSM states,
// coordinate widths and default image geometry.
package pupil_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 384;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    UPDATE,
    DONE
  } state_t;

endpackage

// File: rtl/roi_raster_counter.sv
// Raster walker over a latched ROI: load bounds, step by STEP, flag last.
// Ports: clk/rst_n, load+bounds, step, x/y position, last position flag.
module roi_raster_counter
  import pupil_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [X_W-1:0] xmin,
  input  logic [X_W-1:0] xmax,
  input  logic [Y_W-1:0] ymin,
  input  logic [Y_W-1:0] ymax,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  localparam logic [X_W:0] X_STEP = STEP[X_W:0];
  localparam logic [Y_W:0] Y_STEP = STEP[Y_W:0];

  logic [X_W-1:0] x_lo;
  logic [X_W-1:0] x_hi;
  logic [Y_W-1:0] y_hi;
  logic [X_W:0]   x_nxt;
  logic [Y_W:0]   y_nxt;
  logic           x_end;
  logic           y_end;

  // one extra bit so the sum never wraps at the image edge
  assign x_nxt = {1'b0, x} + X_STEP;
  assign y_nxt = {1'b0, y} + Y_STEP;
  assign x_end = x_nxt > {1'b0, x_hi};
  assign y_end = y_nxt > {1'b0, y_hi};
  assign last  = x_end & y_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lo <= '0;
      x_hi <= '0;
      y_hi <= '0;
      x    <= '0;
      y    <= '0;
    end else if (load) begin
      x_lo <= xmin;
      x_hi <= xmax;
      y_hi <= ymax;
      x    <= xmin;
      y    <= ymin;
    end else if (step && !last) begin
      if (!x_end) begin
        x <= x_nxt[X_W-1:0];
      end else begin
        x <= x_lo;
        y <= y_nxt[Y_W-1:0];
      end
    end
  end

  logic unused;
  assign unused = ^ymin[0];

endmodule

// File: rtl/pupil_scan_scheduler.sv
// Scans an ROI with a correlator, keeps the argmax and reports it.
// Ports: frame start + ROI in, corr start/done handshake, result out,
// busy, drop counter. Optional macro SCAN_TIMEOUT_EN adds oTimeout.
module pupil_scan_scheduler
  import pupil_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int CORR_W  = 16,
  parameter int STEP    = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iFrameDone,
  input  logic [X_W-1:0]    iXmin,
  input  logic [X_W-1:0]    iXmax,
  input  logic [Y_W-1:0]    iYmin,
  input  logic [Y_W-1:0]    iYmax,
  output logic              oCorrStart,
  output logic [X_W-1:0]    oX,
  output logic [Y_W-1:0]    oY,
  input  logic              iCorrDone,
  input  logic [CORR_W-1:0] iCorrValue,
  output logic [X_W-1:0]    oXresult,
  output logic [Y_W-1:0]    oYresult,
  output logic [CORR_W-1:0] oBestCorr,
  output logic              oResultValid,
  output logic              oBusy,
  output logic [7:0]        oDropCnt
`ifdef SCAN_TIMEOUT_EN
  ,
  output logic              oTimeout
`endif
);

  localparam logic [X_W-1:0] X_TOP = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_TOP = Y_W'(IMG_H - 1);

  state_t state;
  state_t nxt;

  logic [X_W-1:0]    x_lo;
  logic [X_W-1:0]    x_hi;
  logic [Y_W-1:0]    y_lo;
  logic [Y_W-1:0]    y_hi;
  logic              roi_ok;
  logic              ld;
  logic              stp;
  logic              last;
  logic              first;
  logic [CORR_W-1:0] corr_q;
  logic [CORR_W-1:0] best;
  logic [X_W-1:0]    best_x;
  logic [Y_W-1:0]    best_y;

  assign x_lo = (iXmin > X_TOP) ? X_TOP : iXmin;
  assign x_hi = (iXmax > X_TOP) ? X_TOP : iXmax;
  assign y_lo = (iYmin > Y_TOP) ? Y_TOP : iYmin;
  assign y_hi = (iYmax > Y_TOP) ? Y_TOP : iYmax;

  assign roi_ok = (x_lo <= x_hi) && (y_lo <= y_hi);

  assign oCorrStart = (state == ISSUE);
  assign oBusy      = (state != IDLE);

`ifdef SCAN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;
  logic          tmo;

  assign tmo = (state == WAIT) && !iCorrDone &&
               (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wait_cnt <= '0;
      oTimeout <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (ld)
        oTimeout <= 1'b0;
      else if (tmo)
        oTimeout <= 1'b1;
    end
  end
`else
  logic tmo;
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt = state;
    ld  = 1'b0;
    stp = 1'b0;
    unique case (state)
      IDLE: begin
        if (iFrameDone) begin
          ld  = 1'b1;
          nxt = roi_ok ? ISSUE : DONE;
        end
      end
      ISSUE:  nxt = WAIT;
      WAIT: begin
        if (iCorrDone || tmo)
          nxt = UPDATE;
      end
      UPDATE: begin
        stp = 1'b1;
        nxt = last ? DONE : ISSUE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= IDLE;
      first        <= 1'b0;
      corr_q       <= '0;
      best         <= '0;
      best_x       <= '0;
      best_y       <= '0;
      oXresult     <= '0;
      oYresult     <= '0;
      oBestCorr    <= '0;
      oResultValid <= 1'b0;
      oDropCnt     <= '0;
    end else begin
      state        <= nxt;
      oResultValid <= 1'b0;
      if (iFrameDone && state != IDLE && oDropCnt != 8'hFF)
        oDropCnt <= oDropCnt + 8'd1;
      // an empty ROI reports its own corner with score 0
      if (ld) begin
        first  <= 1'b1;
        best   <= '0;
        best_x <= x_lo;
        best_y <= y_lo;
      end
      if (state == WAIT && iCorrDone)
        corr_q <= iCorrValue;
      else if (tmo)
        corr_q <= '0;
      // strict compare keeps the earliest raster position on ties
      if (state == UPDATE) begin
        first <= 1'b0;
        if (first || corr_q > best) begin
          best   <= corr_q;
          best_x <= oX;
          best_y <= oY;
        end
      end
      if (state == DONE) begin
        oXresult     <= best_x;
        oYresult     <= best_y;
        oBestCorr    <= best;
        oResultValid <= 1'b1;
      end
    end
  end

  roi_raster_counter #(
    .STEP (STEP)
  ) u_raster (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .load  (ld),
    .step  (stp),
    .xmin  (x_lo),
    .xmax  (x_hi),
    .ymin  (y_lo),
    .ymax  (y_hi),
    .x     (oX),
    .y     (oY),
    .last  (last)
  );

endmodule

// File: tb/tb_pupil_scan_scheduler.sv
// Bench: two schedulers (STEP 1 and 2) driven by a randomized
// correlator, checked against a raster/argmax reference model.
module tb_pupil_scan_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        fd  [2];
  logic [9:0]  xmn [2];
  logic [9:0]  xmx [2];
  logic [8:0]  ymn [2];
  logic [8:0]  ymx [2];
  logic        cs  [2];
  logic        cd  [2];
  logic [15:0] cv  [2];
  logic [9:0]  ox  [2];
  logic [8:0]  oy  [2];
  logic [9:0]  xr  [2];
  logic [8:0]  yr  [2];
  logic [15:0] bc  [2];
  logic        rvld[2];
  logic        busy[2];
  logic [7:0]  drop[2];
`ifdef SCAN_TIMEOUT_EN
  logic        tmo [2];
`endif

  pupil_scan_scheduler dut0 (
    .iCLK(clk), .iRST_N(rst_n), .iFrameDone(fd[0]),
    .iXmin(xmn[0]), .iXmax(xmx[0]),
    .iYmin(ymn[0]), .iYmax(ymx[0]),
    .oCorrStart(cs[0]), .oX(ox[0]), .oY(oy[0]),
    .iCorrDone(cd[0]), .iCorrValue(cv[0]),
    .oXresult(xr[0]), .oYresult(yr[0]), .oBestCorr(bc[0]),
    .oResultValid(rvld[0]), .oBusy(busy[0]),
    .oDropCnt(drop[0])
`ifdef SCAN_TIMEOUT_EN
    , .oTimeout(tmo[0])
`endif
  );

  pupil_scan_scheduler #(.STEP(2)) dut1 (
    .iCLK(clk), .iRST_N(rst_n), .iFrameDone(fd[1]),
    .iXmin(xmn[1]), .iXmax(xmx[1]),
    .iYmin(ymn[1]), .iYmax(ymx[1]),
    .oCorrStart(cs[1]), .oX(ox[1]), .oY(oy[1]),
    .iCorrDone(cd[1]), .iCorrValue(cv[1]),
    .oXresult(xr[1]), .oYresult(yr[1]), .oBestCorr(bc[1]),
    .oResultValid(rvld[1]), .oBusy(busy[1]),
    .oDropCnt(drop[1])
`ifdef SCAN_TIMEOUT_EN
    , .oTimeout(tmo[1])
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  bit dir_mode = 1'b0;
  int seed = 0;
  bit silent[2];
  int stray_req[2];
  int stray_done[2];
  int rv_cnt[2];
  int pend[2];
  int px[2];
  int py[2];
  int posq[2][$];
  int exp_drop[2];

  function automatic int score(input int x, input int y);
    int tbl[6];
    tbl = '{5, 9, 3, 9, 1, 2};
    if (dir_mode) return tbl[y * 3 + x];
    return (x * 37 + y * 11 + seed) % 7;
  endfunction

  // correlator model: answers each start after 1..4 cycles
  initial begin
    for (int g = 0; g < 2; g++) begin
      cd[g] = 1'b0;
      cv[g] = '0;
      pend[g] = 0;
      rv_cnt[g] = 0;
      stray_done[g] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        cd[g] = 1'b0;
        if (rvld[g]) rv_cnt[g]++;
        if (stray_req[g] != stray_done[g]) begin
          stray_done[g]++;
          cd[g] = 1'b1;
          cv[g] = 16'd77;
        end else if (cs[g]) begin
          posq[g].push_back(int'(ox[g]) * 1024 + int'(oy[g]));
          px[g] = int'(ox[g]);
          py[g] = int'(oy[g]);
          pend[g] = $urandom_range(1, 4);
        end else if (pend[g] > 0) begin
          check("hold_pos", int'(ox[g]) * 1024 + int'(oy[g]),
                px[g] * 1024 + py[g]);
          pend[g]--;
          if (pend[g] == 0 && !silent[g]) begin
            cd[g] = 1'b1;
            cv[g] = 16'(score(px[g], py[g]));
          end
        end
      end
    end
  end

  task automatic run_scan(input int g, input int x0, input int x1,
                          input int y0, input int y1, input int nd);
    int cx0, cx1, cy0, cy1, s, bx, by, bs, lat, k, bp, br, sc;
    int exp_q[$];
    bit ok;
    s   = (g == 0) ? 1 : 2;
    cx0 = (x0 > 511) ? 511 : x0;
    cx1 = (x1 > 511) ? 511 : x1;
    cy0 = (y0 > 383) ? 383 : y0;
    cy1 = (y1 > 383) ? 383 : y1;
    ok  = (cx0 <= cx1) && (cy0 <= cy1);
    bx = cx0;
    by = cy0;
    bs = 0;
    if (ok) begin
      for (int y = cy0; y <= cy1; y += s) begin
        for (int x = cx0; x <= cx1; x += s) begin
          sc = score(x, y);
          if (exp_q.size() == 0 || sc > bs) begin
            bx = x;
            by = y;
            bs = sc;
          end
          exp_q.push_back(x * 1024 + y);
        end
      end
    end
    bp = posq[g].size();
    br = rv_cnt[g];
    @(posedge clk);
    #1;
    fd[g]  = 1'b1;
    xmn[g] = 10'(x0);
    xmx[g] = 10'(x1);
    ymn[g] = 9'(y0);
    ymx[g] = 9'(y1);
    @(posedge clk);
    #1;
    fd[g] = 1'b0;
    lat = 1;
    for (int i = 0; i < nd; i++) begin
      fd[g]  = 1'b1;
      xmn[g] = 10'($urandom);
      xmx[g] = 10'($urandom);
      ymn[g] = 9'($urandom);
      ymx[g] = 9'($urandom);
      @(posedge clk);
      #1;
      fd[g] = 1'b0;
      @(posedge clk);
      #1;
      lat += 2;
      if (exp_drop[g] < 255) exp_drop[g]++;
    end
    k = 0;
    while (!rvld[g] && k < 4000) begin
      @(posedge clk);
      #1;
      lat++;
      k++;
    end
    check("result_seen", int'(k < 4000), 1);
    if (!ok && nd == 0) check("empty_latency", lat, 2);
    repeat (3) @(posedge clk);
    #1;
    check("valid_pulses", rv_cnt[g] - br, 1);
    check("starts", posq[g].size() - bp, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (bp + i < posq[g].size())
        check("pos", posq[g][bp + i], exp_q[i]);
    end
    check("xres", int'(xr[g]), bx);
    check("yres", int'(yr[g]), by);
    check("score", int'(bc[g]), bs);
    check("idle", int'(busy[g]), 0);
    check("drops", int'(drop[g]), exp_drop[g]);
  endtask

  initial begin
    int x0, x1, y0, y1, g, nd, br, bp;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fd[i] = 1'b0;
      xmn[i] = '0;
      xmx[i] = '0;
      ymn[i] = '0;
      ymx[i] = '0;
      silent[i] = 1'b0;
      stray_req[i] = 0;
      exp_drop[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_xres", int'(xr[i]), 0);
      check("rst_yres", int'(yr[i]), 0);
      check("rst_score", int'(bc[i]), 0);
      check("rst_valid", int'(rvld[i]), 0);
      check("rst_busy", int'(busy[i]), 0);
      check("rst_drop", int'(drop[i]), 0);
      check("rst_start", int'(cs[i]), 0);
      check("rst_x", int'(ox[i]), 0);
      check("rst_y", int'(oy[i]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    dir_mode = 1'b1;
    run_scan(0, 0, 2, 0, 1, 0);
    dir_mode = 1'b0;
    run_scan(1, 509, 511, 382, 383, 0);
    run_scan(0, 509, 1023, 382, 511, 0);
    run_scan(0, 10, 5, 7, 9, 0);
    run_scan(1, 3, 3, 20, 10, 0);
    dir_mode = 1'b1;
    run_scan(0, 0, 2, 0, 1, 3);
    dir_mode = 1'b0;

    for (int n = 0; n < 24; n++) begin
      g = n % 2;
      seed = $urandom_range(0, 100);
      x0 = ($urandom_range(0, 3) == 0) ?
           $urandom_range(505, 1023) : $urandom_range(0, 511);
      y0 = ($urandom_range(0, 3) == 0) ?
           $urandom_range(378, 511) : $urandom_range(0, 383);
      x1 = x0 + $urandom_range(0, 5);
      y1 = y0 + $urandom_range(0, 4);
      if (x1 > 1023) x1 = 1023;
      if (y1 > 511) y1 = 511;
      if ($urandom_range(0, 7) == 0 && x0 > 0) x1 = x0 - 1;
      nd = (x1 >= x0 && y1 >= y0) ? $urandom_range(0, 2) : 0;
      run_scan(g, x0, x1, y0, y1, nd);
    end

    // abort a scan stuck in WAIT while flooding frame pulses
    silent[0] = 1'b1;
    @(posedge clk);
    #1;
    fd[0]  = 1'b1;
    xmn[0] = 10'd5;
    xmx[0] = 10'd7;
    ymn[0] = 9'd3;
    ymx[0] = 9'd4;
    @(posedge clk);
    #1;
    fd[0] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      fd[0] = 1'b1;
      @(posedge clk);
      #1;
      fd[0] = 1'b0;
      @(posedge clk);
      #1;
    end
    check("drop_sat", int'(drop[0]), 255);
    check("busy_wait", int'(busy[0]), 1);
    check("x_wait", int'(ox[0]), 5);
    check("y_wait", int'(oy[0]), 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy[0]), 0);
    check("abort_x", int'(ox[0]), 0);
    check("abort_y", int'(oy[0]), 0);
    check("abort_drop", int'(drop[0]), 0);
    check("abort_xres", int'(xr[0]), 0);
    check("abort_yres", int'(yr[0]), 0);
    check("abort_score", int'(bc[0]), 0);
    check("abort_valid", int'(rvld[0]), 0);
    check("abort_start", int'(cs[0]), 0);
    check("abort_xres1", int'(xr[1]), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    silent[0] = 1'b0;
    exp_drop[0] = 0;
    exp_drop[1] = 0;
    br = rv_cnt[0];
    bp = posq[0].size();
    stray_req[0]++;
    repeat (5) @(posedge clk);
    #1;
    check("stray_busy", int'(busy[0]), 0);
    check("stray_valid", rv_cnt[0] - br, 0);
    check("stray_start", posq[0].size() - bp, 0);
    check("stray_xres", int'(xr[0]), 0);
    seed = 3;
    run_scan(0, 1, 2, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
